// File: rtl/gray_lbp_mem.sv
// ============================================================================
// Module      : gray_lbp_mem
// Description : Gray-frame image memory and LBP result memory with host
//               load, LBP read/write service and host result readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_lbp_mem #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err_border
);

    localparam int                DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = '1;
    localparam logic [ADDR_W:0]   c_wr_max    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_img_w     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_edge      = ADDR_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_gmem [DEPTH];
    logic [DATA_W-1:0] r_lmem [DEPTH];

    logic              w_load_we;
    logic              w_lbp_we;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic              w_border;

    assign w_load_we = (r_state == ST_LOAD)  && load_valid;
    assign w_lbp_we  = (r_state == ST_SERVE) && lbp_valid;
    assign w_row     = lbp_addr / c_img_w;
    assign w_col     = lbp_addr % c_img_w;
    assign w_border  = (w_row == '0) || (w_row == c_edge) ||
                       (w_col == '0) || (w_col == c_edge);

    // Arrays carry no reset so they can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_gmem[r_ptr] <= load_data;
        end
        if (w_lbp_we) begin
            r_lmem[lbp_addr] <= lbp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_LOAD;
            r_ptr      <= '0;
            gray_ready <= 1'b0;
            gray_data  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
            err_border <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (load_valid) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (r_ptr == c_last_addr) begin
                            r_state    <= ST_SERVE;
                            gray_ready <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (gray_req) begin
                        gray_data <= r_gmem[gray_addr];
                    end
                    if (lbp_valid) begin
                        if (wr_count != c_wr_max) begin
                            wr_count <= wr_count + 1'b1;
                        end
                        if (w_border) begin
                            err_border <= 1'b1;
                        end
                    end
                    if (finish) begin
                        r_state    <= ST_DONE;
                        gray_ready <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    rd_valid <= rd_req;
                    if (rd_req) begin
                        rd_data <= r_lmem[rd_addr];
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/gray_lbp_mem.md
# gray_lbp_mem

Image-memory responder for the LBP engine. Holds one 128x128 8-bit grayscale frame, serves `gray_addr`/`gray_req` reads with a registered one-cycle response, and captures every `lbp_addr`/`lbp_valid`/`lbp_data` write into a result memory. After `finish`, it exposes the result memory to the host through a readback port. It sits between the host/loader and the LBP core and replaces the behavioural memory model with synthesizable RTL.

## Interface

Parameters:

- `ADDR_W`, 14, pixel address width (frame = 2^ADDR_W bytes)
- `DATA_W`, 8, pixel width
- `IMG_W`, 128, row length in pixels (used for border detection)

Ports:

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  host pixel-load strobe
- `load_data`  in  DATA_W  pixel to store at the internal load pointer
- `gray_ready`  out  1  frame loaded, read service active
- `gray_req`  in  1  LBP read request
- `gray_addr`  in  ADDR_W  LBP read address
- `gray_data`  out  DATA_W  registered read data
- `lbp_valid`  in  1  LBP write strobe
- `lbp_addr`  in  ADDR_W  LBP write address
- `lbp_data`  in  DATA_W  LBP result byte
- `finish`  in  1  LBP completion
- `rd_req`  in  1  host result-read request
- `rd_addr`  in  ADDR_W  host result-read address
- `rd_data`  out  DATA_W  registered result data
- `rd_valid`  out  1  `rd_data` valid this cycle
- `done`  out  1  result memory readable
- `wr_count`  out  ADDR_W+1  accepted LBP writes, saturating
- `err_border`  out  1  sticky: LBP write hit a border pixel

## Operation

- Two arrays: `gmem[2^ADDR_W]` holds gray pixels; `lmem[2^ADDR_W]` holds LBP results. Reset does not clear the arrays.
- FSM states: LOAD, SERVE, DONE. Reset enters LOAD.
- LOAD:
  - When `load_valid`=1, write `gmem[ptr] <= load_data` and increment `ptr`.
  - When the write at `ptr`=2^ADDR_W-1 is accepted, go to SERVE. `ptr` wraps to 0.
  - `gray_req`, `lbp_valid`, `finish`, and `rd_req` are ignored.
- SERVE:
  - `gray_ready`=1.
  - When `gray_req`=1, `gray_data <= gmem[gray_addr]`. Otherwise `gray_data` holds its value.
  - When `lbp_valid`=1, write `lmem[lbp_addr] <= lbp_data` and increment `wr_count`, saturating at 2^ADDR_W.
  - A write is a border write if row is 0 or IMG_W-1, or column (`lbp_addr % IMG_W`) is 0 or IMG_W-1. A border write still lands in memory and sets `err_border`, which stays set until reset.
  - Repeated writes to the same address each count.
  - `load_valid` and `rd_req` are ignored.
  - When `finish`=1, go to DONE. An `lbp_valid` in the same cycle is still written and counted.
- DONE:
  - `done`=1, `gray_ready`=0.
  - When `rd_req`=1, `rd_data <= lmem[rd_addr]` and `rd_valid <= 1`. Otherwise `rd_valid <= 0` and `rd_data` holds.
  - `gray_req`, `lbp_valid`, and `load_valid` are ignored.
  - DONE is terminal; only reset leaves it.

## Timing

- Reset values: `gray_ready`=0, `gray_data`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `wr_count`=0, `err_border`=0, `ptr`=0, state LOAD.
- `gray_ready` rises in the cycle after the final load write. `gray_data` has 1-cycle latency: request sampled at edge N, data valid after edge N and held until the next accepted request.
- Back-to-back `gray_req` gives one new datum per cycle.
- `lmem` write has 0 cycles of visible latency into DONE. A read in the first DONE cycle returns the data written together with `finish`.
- `done` rises the cycle after `finish` is sampled.
- `rd_valid` pulses 1 cycle after each sampled `rd_req`.
- `gray_ready`, `done`, `rd_valid`, `gray_data`, and `rd_data` are registered; there are no combinational input-to-output paths.
- Reset asserted mid-operation:
  - All registers return to their reset values immediately (asynchronous).
  - A subsequent frame load starts at address 0.
  - A partial load before reset is discarded logically.

## Test plan

- **Full load:** 16384 `load_valid` pulses with `load_data = addr[7:0]`, with 3 idle gaps inserted.
  - `gray_ready` is 0 through the last write and 1 on the next cycle.
  - `gray_req` on address 0x0081 returns 0x81 one cycle later.
- **Streaming reads:** `gray_req` held for addresses 0x0000..0x0008 on consecutive cycles.
  - `gray_data` = 0x00..0x08, each lagging its address by 1 cycle.
  - With `gray_req`=0, `gray_data` holds 0x08.
- **Writes with finish:** 3 writes (0x0081←0xA5, 0x0082←0x5A, 0x3EFE←0xFF), the last one coincident with `finish`.
  - `done`=1 next cycle; `wr_count`=3; `err_border`=0.
  - Reading 0x3EFE returns 0xFF with `rd_valid` 1 cycle after `rd_req`.
- **Border write:** `lbp_addr`=0x0080 (column 0) with `lbp_valid`.
  - `err_border`=1 and stays set through later interior writes.
  - `wr_count` increments.
- **Ignored inputs:**
  - `rd_req` during SERVE → `rd_valid` stays 0.
  - `lbp_valid` during LOAD → `wr_count` stays 0.
  - `load_valid` during SERVE → `gmem[0]` unchanged (still reads 0x00).
- **Reset mid-load:** assert `reset`=0 after 100 loads, release, then load a full frame of 0x33.
  - `gray_ready` rises only after 16384 new writes.
  - Address 0x0010 reads 0x33.
